// File: rtl/alu_result_serializer_if.sv
// Bus between the ALU result stage and the UART TX byte stream.
// The serializer is the slave; the producer/consumer side is the master.
interface alu_result_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [2*DATA_WIDTH-1:0] alu_out;
  logic                    out_valid;
  logic                    byte_ready;
  logic                    clr_ovf;
  logic [DATA_WIDTH-1:0]   byte_data;
  logic                    byte_valid;
  logic                    busy;
  logic                    overflow;

  modport slave (
    input  alu_out, out_valid, byte_ready, clr_ovf,
    output byte_data, byte_valid, busy, overflow
  );

  modport master (
    output alu_out, out_valid, byte_ready, clr_ovf,
    input  byte_data, byte_valid, busy, overflow
  );
endinterface

// File: rtl/alu_result_serializer.sv
// Buffers 2*DATA_WIDTH-bit ALU results and streams each one out as two
// DATA_WIDTH-bit bytes, LSB first, over a valid/ready handshake.
module alu_result_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input logic                   CLK,
  input logic                   RST,
  alu_result_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  state_t                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   byte_data_q, byte_data_d;
  logic                    byte_valid_q, byte_valid_d;
  logic                    overflow_q, overflow_d;
  logic                    pop, wr_en, drop, empty, full;
  logic [2*DATA_WIDTH-1:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop on the same edge frees a slot, so a full buffer can still accept.
  assign wr_en = bus.out_valid && (!full || pop);
  assign drop  = bus.out_valid && full && !pop;

  always_comb begin
    state_d      = state_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    hold_d       = hold_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        byte_valid_d = 1'b0;
        if (!empty) begin
          pop          = 1'b1;
          hold_d       = head[2*DATA_WIDTH-1:DATA_WIDTH];
          byte_data_d  = head[DATA_WIDTH-1:0];
          byte_valid_d = 1'b1;
          state_d      = SEND_LO;
        end
      end
      SEND_LO: begin
        if (bus.byte_ready) begin
          byte_data_d = hold_q;
          state_d     = SEND_HI;
        end
      end
      SEND_HI: begin
        if (bus.byte_ready) begin
          if (!empty) begin
            pop         = 1'b1;
            hold_d      = head[2*DATA_WIDTH-1:DATA_WIDTH];
            byte_data_d = head[DATA_WIDTH-1:0];
            state_d     = SEND_LO;
          end else begin
            byte_valid_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: begin
        byte_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hold_q       <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      overflow_q   <= overflow_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage carries no reset: emptiness is defined purely by the pointers.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.alu_out;
  end

  assign bus.byte_data  = byte_data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state_q != IDLE) || !empty;
endmodule
